frame_sequencer: RTL and testbench
==================================

FRAME_SEQUENCER -- requirements
Module: frame_sequencer

Interface
REQ-001 SHALL provide parameter JUMP_FRAMES, default 20, number of frames the character ascends per jump (1..63).
REQ-002 SHALL provide parameter SHIFT_DIV, default 1, background scrolls one column every SHIFT_DIV frames (1..15).
REQ-003 clk  input  1  system clock; all state changes on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 frame_tick  input  1  one-cycle pulse marking the start of a frame.
REQ-006 jump_btn  input  1  level jump request, already synchronised to clk.
REQ-007 doneP  input  1  background raster complete, from the datapath.
REQ-008 doneC  input  1  character sprite raster complete, from the datapath.
REQ-009 ground  input  1  character on ground, from the datapath.
REQ-010 drawB, drawC, enableX, enableCountXC, enableShift, countUp, countDown  output  1 each  datapath controls.
REQ-011 plot  output  1  VGA write enable.
REQ-012 busy  output  1  high in any state except IDLE.
REQ-013 overrun  output  1  sticky flag: a frame_tick arrived while busy.

Function
REQ-014 SHALL implement the states IDLE, SHIFT, DRAW_BG, PHYS, DRAW_CHAR; all outputs SHALL be registered Moore outputs.
REQ-015 IDLE: frame_tick=1 -> SHIFT; otherwise hold, with all datapath controls at 0.
REQ-016 SHIFT: one cycle; enableShift=1 only when the 4-bit frame divider equals SHIFT_DIV-1; the divider then wraps to 0, else increments; next state DRAW_BG.
REQ-017 DRAW_BG: drawB=1, enableX=1, plot=1, drawC=0; hold until doneP=1, then go to PHYS; plot SHALL drop in the same cycle drawB drops.
REQ-018 PHYS: one cycle; drawB=drawC=0, plot=0; countUp/countDown asserted per REQ-021..REQ-024 for exactly this one cycle; next state DRAW_CHAR.
REQ-019 DRAW_CHAR: drawC=1, enableCountXC=1, plot=1, drawB=0; hold until doneC=1, then go to IDLE.
REQ-020 drawB and drawC SHALL never be high in the same cycle; countUp and countDown SHALL never be high in the same cycle.
REQ-021 Jump request: a rising edge of jump_btn (registered previous value) SHALL set jump_pending in any state; it is cleared only when consumed or on reset.
REQ-022 Jump start: in PHYS with jump_pending=1, ground=1 and airborne=0 -> countUp=1, airborne=1, ascending=1, jump_cnt=1, jump_pending cleared. A jump edge while airborne stays pending until landing.
REQ-023 Ascent: in PHYS with ascending=1 -> countUp=1 and jump_cnt increments (6-bit); when jump_cnt reaches JUMP_FRAMES, ascending clears in the same cycle and no further countUp is issued.
REQ-024 Descent: in PHYS with airborne=1 and ascending=0 -> countDown=1 if ground=0; if ground=1, countDown=0, airborne clears and jump_cnt returns to 0.
REQ-025 Overrun: frame_tick=1 while the state is not IDLE SHALL set overrun; the tick is dropped (not queued). overrun clears only on reset.
REQ-026 doneP in any state other than DRAW_BG, and doneC in any state other than DRAW_CHAR, SHALL be ignored.
REQ-027 Latency: frame_tick to the first drawB=1 cycle SHALL be 2 cycles (IDLE->SHIFT->DRAW_BG).

Reset
REQ-028 reset=1 SHALL force IDLE from any state, including mid-raster, in the next cycle.
REQ-029 On reset all outputs SHALL be 0; jump_pending, airborne, ascending, jump_cnt, the frame divider and the previous-jump register SHALL be 0.
REQ-030 reset SHALL take priority over frame_tick, doneP, doneC and jump_btn in the same cycle.

Verification
REQ-031 Basic frame: reset, then frame_tick -> enableShift pulses 1 cycle later, drawB=plot=1 from cycle 2; assert doneP on cycle 10 -> one PHYS cycle with no count; drawC=1 until doneC; then IDLE, busy=0.
REQ-032 Jump, JUMP_FRAMES=3, ground=1: pulse jump_btn, run frames -> countUp in PHYS of frames 1, 2, 3; ground=0 frames 4..6 -> countDown in each; ground=1 frame 7 -> no count, airborne=0.
REQ-033 Jump held high across frames -> exactly one jump; second press while airborne -> new jump starts on the first PHYS after landing.
REQ-034 SHIFT_DIV=3, 7 frames -> enableShift in frames 3 and 6 only.
REQ-035 frame_tick during DRAW_BG -> overrun=1 and stays 1; frame sequence unaffected; next tick in IDLE starts a frame normally.
REQ-036 reset asserted during DRAW_CHAR while airborne -> next cycle IDLE, all outputs 0, airborne=0; a stray doneC in IDLE causes no transition.

Source files
------------

// File: rtl/frame_sequencer.sv
// Per-frame control sequencer: scroll the background, redraw it, step the jump physics,
// then redraw the character sprite. Every output is a flop driven from next-state decode.
module frame_sequencer #(
  parameter int JUMP_FRAMES = 20,
  parameter int SHIFT_DIV   = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic frame_tick,
  input  logic jump_btn,
  input  logic doneP,
  input  logic doneC,
  input  logic ground,
  output logic drawB,
  output logic drawC,
  output logic enableX,
  output logic enableCountXC,
  output logic enableShift,
  output logic countUp,
  output logic countDown,
  output logic plot,
  output logic busy,
  output logic overrun
);

  typedef enum logic [2:0] {
    IDLE,
    SHIFT,
    DRAW_BG,
    PHYS,
    DRAW_CHAR
  } stateType;

  localparam logic [3:0] SHIFT_LAST = 4'(SHIFT_DIV - 1);
  localparam logic [5:0] JUMP_LAST  = 6'(JUMP_FRAMES);
  localparam logic       ONE_FRAME_JUMP = (JUMP_FRAMES == 1);

  stateType    stateReg, stateNext;
  logic [3:0]  divReg, divNext;
  logic        jumpPrevReg;
  logic        jumpPendingReg, jumpPendingNext;
  logic        airborneReg, airborneNext;
  logic        ascendingReg, ascendingNext;
  logic [5:0]  jumpCntReg, jumpCntNext;
  logic        overrunNext;
  logic        shiftNext, upNext, downNext;
  logic        jumpEdge;

  assign jumpEdge = jump_btn & ~jumpPrevReg;

  always_comb begin
    stateNext       = stateReg;
    divNext         = divReg;
    jumpPendingNext = jumpPendingReg | jumpEdge;
    airborneNext    = airborneReg;
    ascendingNext   = ascendingReg;
    jumpCntNext     = jumpCntReg;
    overrunNext     = overrun | (frame_tick & (stateReg != IDLE));
    shiftNext       = 1'b0;
    upNext          = 1'b0;
    downNext        = 1'b0;

    case (stateReg)
      IDLE: begin
        if (frame_tick) begin
          stateNext = SHIFT;
          shiftNext = (divReg == SHIFT_LAST);
          divNext   = shiftNext ? 4'd0 : divReg + 4'd1;
        end
      end
      SHIFT: stateNext = DRAW_BG;
      DRAW_BG: begin
        // Physics is resolved on the edge into PHYS so countUp/countDown are plain flops.
        if (doneP) begin
          stateNext = PHYS;
          if (airborneReg && ascendingReg) begin
            upNext      = 1'b1;
            jumpCntNext = jumpCntReg + 6'd1;
            if (jumpCntNext == JUMP_LAST) begin
              ascendingNext = 1'b0;
            end
          end else if (airborneReg) begin
            if (!ground) begin
              downNext = 1'b1;
            end else begin
              airborneNext = 1'b0;
              jumpCntNext  = 6'd0;
            end
          end else if (jumpPendingReg && ground) begin
            upNext          = 1'b1;
            airborneNext    = 1'b1;
            ascendingNext   = ~ONE_FRAME_JUMP;
            jumpCntNext     = 6'd1;
            jumpPendingNext = jumpEdge;
          end
        end
      end
      PHYS: stateNext = DRAW_CHAR;
      DRAW_CHAR: begin
        if (doneC) begin
          stateNext = IDLE;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stateReg       <= IDLE;
      divReg         <= 4'd0;
      jumpPrevReg    <= 1'b0;
      jumpPendingReg <= 1'b0;
      airborneReg    <= 1'b0;
      ascendingReg   <= 1'b0;
      jumpCntReg     <= 6'd0;
      drawB          <= 1'b0;
      drawC          <= 1'b0;
      enableX        <= 1'b0;
      enableCountXC  <= 1'b0;
      enableShift    <= 1'b0;
      countUp        <= 1'b0;
      countDown      <= 1'b0;
      plot           <= 1'b0;
      busy           <= 1'b0;
      overrun        <= 1'b0;
    end else begin
      stateReg       <= stateNext;
      divReg         <= divNext;
      jumpPrevReg    <= jump_btn;
      jumpPendingReg <= jumpPendingNext;
      airborneReg    <= airborneNext;
      ascendingReg   <= ascendingNext;
      jumpCntReg     <= jumpCntNext;
      drawB          <= (stateNext == DRAW_BG);
      enableX        <= (stateNext == DRAW_BG);
      drawC          <= (stateNext == DRAW_CHAR);
      enableCountXC  <= (stateNext == DRAW_CHAR);
      plot           <= (stateNext == DRAW_BG) || (stateNext == DRAW_CHAR);
      enableShift    <= shiftNext;
      countUp        <= upNext;
      countDown      <= downNext;
      busy           <= (stateNext != IDLE);
      overrun        <= overrunNext;
    end
  end

endmodule

// File: tb/tb_frame_sequencer.sv
// Bench for frame_sequencer: reset/vector table, directed jump tables, overrun, reset-in-raster,
// and random frames checked against a frame-level reference model.
module tb_frame_sequencer;

  localparam int JF = 3;
  localparam int SD = 3;

  logic clk = 1'b0;
  logic reset, frame_tick, jump_btn, doneP, doneC, ground;
  logic drawB, drawC, enableX, enableCountXC, enableShift, countUp, countDown, plot, busy, overrun;

  always #5 clk = ~clk;

  frame_sequencer #(.JUMP_FRAMES(JF), .SHIFT_DIV(SD)) dut (
    .clk(clk), .reset(reset), .frame_tick(frame_tick), .jump_btn(jump_btn),
    .doneP(doneP), .doneC(doneC), .ground(ground),
    .drawB(drawB), .drawC(drawC), .enableX(enableX), .enableCountXC(enableCountXC),
    .enableShift(enableShift), .countUp(countUp), .countDown(countDown),
    .plot(plot), .busy(busy), .overrun(overrun)
  );

  int total = 0;
  int bad = 0;

  // Reference model: frames since reset, remaining ascent frames, in-air flag, pending request
  int mFrames, mUpLeft;
  bit mInAir, mPending, mPrevBtn, mOvr;

  typedef struct {bit tick; bit dP; bit dC; logic [9:0] exp;} vecType;
  typedef struct {bit g; bit btn; bit up; bit dn;} dirType;
  vecType vecTab[10];
  dirType dirTab[19];

  // Vector order: busy drawB drawC enableX enableCountXC plot enableShift countUp countDown overrun
  function automatic logic [9:0] expVec(int st, bit sh, bit up, bit dn, bit ov);
    return {st != 0, st == 2, st == 4, st == 2, st == 4, (st == 2) || (st == 4), sh, up, dn, ov};
  endfunction

  function automatic logic [9:0] actVec();
    return {busy, drawB, drawC, enableX, enableCountXC, plot, enableShift, countUp, countDown, overrun};
  endfunction

  task automatic check(string name, logic [9:0] act, logic [9:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b want %b", name, act, exp);
    end
  endtask

  task automatic checkBit(string name, bit act, bit exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0b want %0b", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic modelReset();
    mFrames = 0; mUpLeft = 0; mInAir = 0; mPending = 0; mPrevBtn = 0; mOvr = 0;
  endtask

  task automatic modelPhys(input bit g, output bit up, output bit dn);
    up = 0;
    dn = 0;
    if (mUpLeft > 0) begin
      up = 1;
      mUpLeft--;
    end else if (mInAir) begin
      if (!g) dn = 1;
      else mInAir = 0;
    end else if (mPending && g) begin
      up = 1;
      mInAir = 1;
      mUpLeft = JF - 1;
      mPending = 0;
    end
  endtask

  task automatic runFrame(input bit g, input bit btn, input int bgLen, input int chLen,
                          input bit tickInBg, input bit rstInChar,
                          output bit sawUp, output bit sawDown);
    bit sh, up, dn;
    ground = g;
    jump_btn = btn;
    step();
    if (btn && !mPrevBtn) mPending = 1;
    mPrevBtn = btn;
    check("idle", actVec(), expVec(0, 0, 0, 0, mOvr));
    mFrames++;
    sh = (mFrames % SD) == 0;
    modelPhys(g, up, dn);
    frame_tick = 1;
    step();
    frame_tick = 0;
    check("shift", actVec(), expVec(1, sh, 0, 0, mOvr));
    step();
    check("bg", actVec(), expVec(2, 0, 0, 0, mOvr));
    for (int i = 1; i < bgLen; i++) begin
      if (tickInBg && i == 1) frame_tick = 1;
      doneC = 1'($urandom_range(0, 1));
      step();
      frame_tick = 0;
      doneC = 0;
      if (tickInBg && i == 1) mOvr = 1;
      check("bg_hold", actVec(), expVec(2, 0, 0, 0, mOvr));
    end
    doneP = 1;
    step();
    doneP = 0;
    sawUp = countUp;
    sawDown = countDown;
    check("phys", actVec(), expVec(3, 0, up, dn, mOvr));
    step();
    check("char", actVec(), expVec(4, 0, 0, 0, mOvr));
    if (rstInChar) begin
      reset = 1; doneC = 1; frame_tick = 1;
      step();
      reset = 0; doneC = 0; frame_tick = 0; jump_btn = 0;
      modelReset();
      check("rst_in_char", actVec(), 10'b0);
      $display("frame reset mid-raster: outputs=%b", actVec());
      return;
    end
    for (int i = 1; i < chLen; i++) begin
      doneP = 1'($urandom_range(0, 1));
      step();
      doneP = 0;
      check("char_hold", actVec(), expVec(4, 0, 0, 0, mOvr));
    end
    doneC = 1;
    step();
    doneC = 0;
    check("frame_end", actVec(), expVec(0, 0, 0, 0, mOvr));
    $display("frame %0d ground=%0b btn=%0b shift=%0b up=%0b down=%0b ovr=%0b",
             mFrames, g, btn, sh, sawUp, sawDown, mOvr);
  endtask

  initial begin
    bit u, d;
    int n;
    vecTab[0] = '{1, 0, 0, 10'b1000000000};
    vecTab[1] = '{0, 0, 0, 10'b1101010000};
    vecTab[2] = '{0, 0, 1, 10'b1101010000};
    vecTab[3] = '{0, 0, 0, 10'b1101010000};
    vecTab[4] = '{0, 1, 0, 10'b1000000000};
    vecTab[5] = '{0, 1, 0, 10'b1010110000};
    vecTab[6] = '{0, 0, 0, 10'b1010110000};
    vecTab[7] = '{0, 0, 1, 10'b0000000000};
    vecTab[8] = '{0, 0, 1, 10'b0000000000};
    vecTab[9] = '{0, 1, 0, 10'b0000000000};
    // Single jump: up x3, down while off ground, land, then no motion off ground
    dirTab[0]  = '{1, 1, 1, 0};
    dirTab[1]  = '{1, 0, 1, 0};
    dirTab[2]  = '{1, 0, 1, 0};
    dirTab[3]  = '{0, 0, 0, 1};
    dirTab[4]  = '{0, 0, 0, 1};
    dirTab[5]  = '{0, 0, 0, 1};
    dirTab[6]  = '{1, 0, 0, 0};
    dirTab[7]  = '{0, 0, 0, 0};
    // Button held across frames, then a second press while airborne
    dirTab[8]  = '{1, 1, 1, 0};
    dirTab[9]  = '{1, 1, 1, 0};
    dirTab[10] = '{1, 1, 1, 0};
    dirTab[11] = '{1, 1, 0, 0};
    dirTab[12] = '{1, 1, 0, 0};
    dirTab[13] = '{1, 0, 0, 0};
    dirTab[14] = '{1, 1, 1, 0};
    dirTab[15] = '{1, 0, 1, 0};
    dirTab[16] = '{1, 1, 1, 0};
    dirTab[17] = '{1, 0, 0, 0};
    dirTab[18] = '{1, 0, 1, 0};

    reset = 1; frame_tick = 1; doneP = 1; doneC = 1; jump_btn = 1; ground = 1;
    modelReset();
    step();
    step();
    check("reset_state", actVec(), 10'b0);
    reset = 0; frame_tick = 0; doneP = 0; doneC = 0; jump_btn = 0;
    step();
    check("post_reset_idle", actVec(), 10'b0);

    for (int i = 0; i < 10; i++) begin
      frame_tick = vecTab[i].tick;
      doneP = vecTab[i].dP;
      doneC = vecTab[i].dC;
      step();
      check($sformatf("vec%0d", i), actVec(), vecTab[i].exp);
      $display("vector %0d tick=%0b doneP=%0b doneC=%0b out=%b", i,
               vecTab[i].tick, vecTab[i].dP, vecTab[i].dC, actVec());
    end
    frame_tick = 0; doneP = 0; doneC = 0;
    mFrames = 1;

    for (int i = 0; i < 19; i++) begin
      runFrame(dirTab[i].g, dirTab[i].btn, 2, 2, 0, 0, u, d);
      checkBit($sformatf("dir%0d_up", i), u, dirTab[i].up);
      checkBit($sformatf("dir%0d_down", i), d, dirTab[i].dn);
    end

    runFrame(1, 0, 4, 3, 1, 0, u, d);
    checkBit("overrun_set", overrun, 1'b1);
    runFrame(1, 0, 2, 2, 0, 0, u, d);
    checkBit("overrun_sticky", overrun, 1'b1);

    for (int i = 0; i < 40; i++) begin
      int bl;
      bit tb;
      bl = $urandom_range(1, 5);
      tb = (bl >= 2) && ($urandom_range(0, 7) == 0);
      runFrame($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), bl,
               $urandom_range(1, 5), tb, 0, u, d);
    end

    n = 0;
    while (mInAir && n < 40) begin
      runFrame(1, 0, 2, 2, 0, 0, u, d);
      n++;
    end
    runFrame(1, 0, 1, 1, 0, 0, u, d);
    runFrame(1, 1, 2, 2, 0, 0, u, d);
    checkBit("jump_before_reset", u, 1'b1);
    runFrame(1, 0, 2, 3, 0, 1, u, d);
    doneC = 1;
    step();
    doneC = 0;
    check("stray_doneC_idle", actVec(), 10'b0);
    runFrame(0, 0, 2, 2, 0, 0, u, d);
    checkBit("no_fall_after_reset", d, 1'b0);
    checkBit("no_rise_after_reset", u, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
